// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: converts a 3-bit Gray word to binary, checks that
// successive accepted words differ by exactly one bit, tracks step direction,
// and escalates to FAULT after ERR_LIMIT consecutive bad steps.
//
// state     | meaning
// UNLOCKED  | no reference word held; next sample becomes prev without a check
// LOCKED    | every sample is checked against prev
// FAULT     | too many consecutive bad steps; checking stops until clr
module gray_step_monitor #(
    parameter int ERR_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] g,
    input  logic       g_valid,
    input  logic       clr,
    output logic [2:0] b,
    output logic       b_valid,
    output logic       dir_up,
    output logic       step_err,
    output logic [7:0] err_cnt,
    output logic       locked
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    logic [1:0] state_q,    state_d;
    logic [2:0] prev_q,     prev_d;
    logic [2:0] cons_q,     cons_d;
    logic [2:0] b_q,        b_d;
    logic       b_valid_q,  b_valid_d;
    logic       dir_up_q,   dir_up_d;
    logic       step_err_q, step_err_d;
    logic [7:0] err_cnt_q,  err_cnt_d;
    logic       locked_q,   locked_d;

    logic [2:0] b_new;
    logic [2:0] b_prev;
    logic [2:0] diff;
    logic       dist_one;
    logic       dist_bad;
    logic [3:0] cons_inc;

    // Gray-to-binary conversion of the incoming word and of the stored reference
    always_comb begin
        b_new[2]  = g[2];
        b_new[1]  = g[2] ^ g[1];
        b_new[0]  = g[2] ^ g[1] ^ g[0];
        b_prev[2] = prev_q[2];
        b_prev[1] = prev_q[2] ^ prev_q[1];
        b_prev[0] = prev_q[2] ^ prev_q[1] ^ prev_q[0];
        diff      = g ^ prev_q;
        // odd parity with not all bits set means exactly one bit differs
        dist_one  = (^diff) & ~(&diff);
        dist_bad  = (diff != 3'd0) & ~dist_one;
        cons_inc  = {1'b0, cons_q} + 4'd1;
    end

    // Next-state and output computation; clr only matters in FAULT
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cons_d     = cons_q;
        b_d        = g_valid ? b_new : b_q;
        b_valid_d  = g_valid;
        dir_up_d   = dir_up_q;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_UNLOCKED: begin
                if (g_valid) begin
                    prev_d  = g;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (g_valid) begin
                    prev_d = g;
                    if (dist_one) begin
                        dir_up_d = (b_new == b_prev + 3'd1);
                        cons_d   = 3'd0;
                    end else if (dist_bad) begin
                        step_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        cons_d = cons_inc[2:0];
                        if (cons_inc >= 4'(ERR_LIMIT)) begin
                            state_d = ST_FAULT;
                        end
                    end
                end
            end
            ST_FAULT: begin
                if (clr) begin
                    state_d = ST_UNLOCKED;
                    cons_d  = 3'd0;
                    prev_d  = 3'd0;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    // Register everything; synchronous reset drops any coincident sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UNLOCKED;
            prev_q     <= 3'd0;
            cons_q     <= 3'd0;
            b_q        <= 3'd0;
            b_valid_q  <= 1'b0;
            dir_up_q   <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cons_q     <= cons_d;
            b_q        <= b_d;
            b_valid_q  <= b_valid_d;
            dir_up_q   <= dir_up_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign b        = b_q;
    assign b_valid  = b_valid_q;
    assign dir_up   = dir_up_q;
    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;
    assign locked   = locked_q;

endmodule
